// File: rtl/mod12_pkg.sv
// Shared constants and state encoding for the mod-12 counter checker.
package mod12_pkg;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MOD12_MAX = 4'd11;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_SYNC  = 2'd1,
        CHK_CHECK = 2'd2
    } chk_state_e;
endpackage

// File: rtl/mod12_next.sv
// Next value of a mod-12 up/down counter with parallel load.
module mod12_next
    import mod12_pkg::*;
(
    input  logic [CNT_W-1:0] cur,
    input  logic             load,
    input  logic             mode,
    input  logic [CNT_W-1:0] data_in,
    output logic [CNT_W-1:0] nxt
);
    always_comb begin
        nxt = data_in;
        if (!load) begin
            if (mode) begin
                nxt = (cur == MOD12_MAX) ? '0 : cur + 4'd1;
            end else begin
                nxt = (cur == '0) ? MOD12_MAX : cur - 4'd1;
            end
        end
    end
endmodule

// File: rtl/mod12_counter_checker.sv
// On-line checker for a mod-12 up/down counter: predicts each value from the last observed one.
// Optional MOD12_CHK_WRAP_CNT_EN adds a saturating wrap counter output (wrap_cnt).
//
// state     | meaning
// CHK_IDLE  | checking disabled, prediction held
// CHK_SYNC  | prediction being seeded from observed value, no compare
// CHK_CHECK | every sample compared against prediction
module mod12_counter_checker
    import mod12_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic [CNT_W-1:0] data_in,
    input  logic [CNT_W-1:0] data_out,
    input  logic             chk_en,
    input  logic             clr_err,
    output logic             mismatch,
    output logic [CNT_W-1:0] exp_out,
    output logic [7:0]       err_cnt,
    output logic             err_sticky,
    output logic [1:0]       chk_state
`ifdef MOD12_CHK_WRAP_CNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);
    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] nxt;
    logic             mis_q, mis_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             sticky_q, sticky_d;
    logic             in_check, bad_val, illegal_load, err;

    mod12_next u_next (
        .cur     (data_out),
        .load    (load),
        .mode    (mode),
        .data_in (data_in),
        .nxt     (nxt)
    );

    always_comb begin
        in_check     = (state_q == CHK_CHECK);
        bad_val      = (data_out > MOD12_MAX);
        illegal_load = load && (data_in > MOD12_MAX);
        err          = in_check && ((data_out != exp_q) || bad_val);

        state_d = state_q;
        exp_d   = exp_q;
        if (state_q != CHK_IDLE) begin
            exp_d = nxt;
        end

        case (state_q)
            CHK_IDLE:  if (chk_en) state_d = CHK_SYNC;
            CHK_SYNC:  state_d = CHK_CHECK;
            // an out-of-range value cannot seed a valid prediction, so re-sync
            CHK_CHECK: if (illegal_load || bad_val) state_d = CHK_SYNC;
            default:   state_d = CHK_IDLE;
        endcase
        if (!chk_en) begin
            state_d = CHK_IDLE;
        end

        mis_d     = err;
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (err && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        sticky_d = clr_err ? 1'b0 : (sticky_q | err);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= CHK_IDLE;
            exp_q     <= '0;
            mis_q     <= 1'b0;
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            mis_q     <= mis_d;
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign chk_state  = state_q;
    assign exp_out    = exp_q;
    assign mismatch   = mis_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = sticky_q;

`ifdef MOD12_CHK_WRAP_CNT_EN
    logic [7:0] wrap_q, wrap_d;
    logic       wrap_evt;

    always_comb begin
        wrap_evt = in_check && !load &&
                   ((mode && (data_out == MOD12_MAX)) || (!mode && (data_out == '0)));
        wrap_d = wrap_q;
        if (clr_err) begin
            wrap_d = '0;
        end else if (wrap_evt && (wrap_q != 8'd255)) begin
            wrap_d = wrap_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_cnt = wrap_q;
`endif
endmodule

// File: tb/tb_mod12_counter_checker.sv
// Directed bench for mod12_counter_checker with a cycle-level behavioural model.
module tb_mod12_counter_checker;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0, mode = 1'b1, chk_en = 1'b0, clr_err = 1'b0;
    logic [3:0] data_in = 4'd0, data_out = 4'd0;
    logic       mismatch, err_sticky;
    logic [3:0] exp_out;
    logic [7:0] err_cnt;
    logic [1:0] chk_state;
`ifdef MOD12_CHK_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cnt = 0;

    int m_state, m_exp, m_cnt, m_wrap;
    bit m_mis, m_sticky;
    bit m_err_now, m_wrap_now;

    always #5 clock = ~clock;

    mod12_counter_checker dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .mode       (mode),
        .data_in    (data_in),
        .data_out   (data_out),
        .chk_en     (chk_en),
        .clr_err    (clr_err),
        .mismatch   (mismatch),
        .exp_out    (exp_out),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky),
        .chk_state  (chk_state)
`ifdef MOD12_CHK_WRAP_CNT_EN
        ,
        .wrap_cnt   (wrap_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: what the counter should show next, judged from the observed value.
    function automatic int predict(input int d, input bit ld, input bit md, input int di);
        if (ld) return di;
        if (d > 11) return md ? (d + 1) % 16 : d - 1;
        return md ? (d + 1) % 12 : (d + 11) % 12;
    endfunction

    assign m_err_now  = (m_state == 2) && ((int'(data_out) != m_exp) || (data_out > 4'd11));
    assign m_wrap_now = (m_state == 2) && !load &&
                        ((mode && data_out == 4'd11) || (!mode && data_out == 4'd0));

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state  <= 0;
            m_exp    <= 0;
            m_mis    <= 1'b0;
            m_cnt    <= 0;
            m_sticky <= 1'b0;
            m_wrap   <= 0;
        end else begin
            if (m_state != 0) m_exp <= predict(int'(data_out), load, mode, int'(data_in));
            m_mis    <= m_err_now;
            m_cnt    <= clr_err ? 0 : (m_err_now && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_sticky <= clr_err ? 1'b0 : (m_sticky | m_err_now);
            m_wrap   <= clr_err ? 0 : (m_wrap_now && m_wrap < 255) ? m_wrap + 1 : m_wrap;
            if (!chk_en) m_state <= 0;
            else if (m_state == 0) m_state <= 1;
            else if (m_state == 1) m_state <= 2;
            else if ((load && data_in > 4'd11) || data_out > 4'd11) m_state <= 1;
        end
    end

    always @(negedge clock) begin
        check("model_state", int'(chk_state), m_state);
        check("model_exp", int'(exp_out), m_exp);
        check("model_mismatch", int'(mismatch), int'(m_mis));
        check("model_err_cnt", int'(err_cnt), m_cnt);
        check("model_sticky", int'(err_sticky), int'(m_sticky));
`ifdef MOD12_CHK_WRAP_CNT_EN
        check("model_wrap", int'(wrap_cnt), m_wrap);
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step_count();
        data_out = 4'(cnt);
        tick();
        cnt = mode ? (cnt + 1) % 12 : (cnt + 11) % 12;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_state", int'(chk_state), 0);
        check("rst_exp", int'(exp_out), 0);
        check("rst_mismatch", int'(mismatch), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_sticky", int'(err_sticky), 0);

        reset = 1'b0;
        chk_en = 1'b1;
        mode = 1'b1;
        cnt = 0;
        repeat (30) step_count();
        check("count_err_cnt", int'(err_cnt), 0);
        check("count_state", int'(chk_state), 2);
`ifdef MOD12_CHK_WRAP_CNT_EN
        check("count_wrap", int'(wrap_cnt), 2);
`endif

        while (cnt != 4) step_count();
        data_out = 4'd5;
        tick();
        check("glitch_mismatch", int'(mismatch), 1);
        check("glitch_err_cnt", int'(err_cnt), 1);
        check("glitch_sticky", int'(err_sticky), 1);
        check("glitch_exp", int'(exp_out), 6);
        cnt = 6;
        repeat (3) step_count();
        check("glitch_once_cnt", int'(err_cnt), 1);
        check("glitch_once_mis", int'(mismatch), 0);

        mode = 1'b0;
        load = 1'b1;
        data_in = 4'd9;
        data_out = 4'(cnt);
        tick();
        check("load_exp9", int'(exp_out), 9);
        load = 1'b0;
        data_out = 4'd9;
        tick();
        check("load_exp8", int'(exp_out), 8);
        check("load_err_cnt", int'(err_cnt), 1);

        load = 1'b1;
        data_in = 4'd14;
        data_out = 4'd8;
        tick();
        check("illegal_load_state", int'(chk_state), 1);
        check("illegal_load_err", int'(err_cnt), 1);
        check("illegal_load_mis", int'(mismatch), 0);
        data_out = 4'd14;
        data_in = 4'd3;
        tick();
        check("illegal_skip_state", int'(chk_state), 2);
        check("illegal_skip_err", int'(err_cnt), 1);
        check("illegal_skip_exp", int'(exp_out), 3);
        load = 1'b0;
        cnt = 3;
        repeat (4) step_count();
        check("down_err_cnt", int'(err_cnt), 1);

        data_out = 4'd13;
        tick();
        check("bad13_err_cnt", int'(err_cnt), 2);
        check("bad13_state", int'(chk_state), 1);
        check("bad13_mis", int'(mismatch), 1);
        step_count();
        check("bad13_resync", int'(chk_state), 2);
        repeat (2) step_count();
        check("bad13_after", int'(err_cnt), 2);

        mode = 1'b1;
        data_out = 4'd5;
        repeat (300) tick();
        check("sat_err_cnt", int'(err_cnt), 255);
        check("sat_sticky", int'(err_sticky), 1);
        clr_err = 1'b1;
        tick();
        check("clr_err_cnt", int'(err_cnt), 0);
        check("clr_sticky", int'(err_sticky), 0);
        check("clr_mis", int'(mismatch), 1);
        clr_err = 1'b0;
        repeat (3) tick();
        check("post_clr_cnt", int'(err_cnt), 3);

        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", int'(chk_state), 0);
        check("mid_rst_exp", int'(exp_out), 0);
        check("mid_rst_mis", int'(mismatch), 0);
        check("mid_rst_cnt", int'(err_cnt), 0);
        check("mid_rst_sticky", int'(err_sticky), 0);
        tick();
        tick();
        check("rst_hold_state", int'(chk_state), 0);
        reset = 1'b0;
        cnt = 0;
        step_count();
        check("rel_sync", int'(chk_state), 1);
        step_count();
        check("rel_check", int'(chk_state), 2);
        step_count();
        check("rel_err_cnt", int'(err_cnt), 0);
        check("rel_mis", int'(mismatch), 0);

        chk_en = 1'b0;
        step_count();
        check("dis_state", int'(chk_state), 0);
        repeat (3) step_count();
        check("dis_err_cnt", int'(err_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
